// File: rtl/score_event_scheduler_if.sv
// Bundle between the main-screen collision detector, the indications display and the scheduler.
// slave = scheduler side, master = the environment that drives collisions and consumes score/life.
interface score_event_scheduler_if;
    logic        startOfFrame;
    logic        start;
    logic        pause;
    logic        reset_level_pulse;
    logic        collisionBallObstacleGood;
    logic        collisionBallObstacleBad;
    logic        collisionBallBumper;
    logic        collisionBallCredit;
    logic        collisionBallBottom;
    logic [15:0] score;
    logic [3:0]  life;
    logic [1:0]  comboLevel;
    logic        scoreEvent;
    logic        gameOver;

    modport slave (
        input  startOfFrame, start, pause, reset_level_pulse,
        input  collisionBallObstacleGood, collisionBallObstacleBad, collisionBallBumper,
        input  collisionBallCredit, collisionBallBottom,
        output score, life, comboLevel, scoreEvent, gameOver
    );

    modport master (
        output startOfFrame, start, pause, reset_level_pulse,
        output collisionBallObstacleGood, collisionBallObstacleBad, collisionBallBumper,
        output collisionBallCredit, collisionBallBottom,
        input  score, life, comboLevel, scoreEvent, gameOver
    );
endinterface

// File: rtl/score_event_scheduler.sv
// Serializes collision events into one score/life update per clock; owns IDLE/PLAY/OVER phase.
// Latency: edge in cycle n, serviced n+1, visible n+2; pause holds servicing. Combo: SCORE_COMBO_EN.
module score_event_scheduler #(
    parameter int POINTS_GOOD   = 10,
    parameter int POINTS_BAD    = 5,
    parameter int POINTS_BUMPER = 1,
    parameter int INIT_LIFE     = 3,
    parameter int LIFE_MAX      = 9,
    parameter int COMBO_WINDOW  = 60
) (
    input logic                     clk,
    input logic                     resetN,
    score_event_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_OVER} state_t;

    // Pending-bit index doubles as arbitration priority: higher index wins.
    localparam int SRC_BUMPER = 0;
    localparam int SRC_GOOD   = 1;
    localparam int SRC_BAD    = 2;
    localparam int SRC_CREDIT = 3;
    localparam int SRC_BOTTOM = 4;

    state_t      state_q;
    logic [4:0]  coll_now, coll_prev_q, coll_ev;
    logic [4:0]  pend_q, pend_d, grant;
    logic        start_prev_q, start_ev;
    logic [15:0] score_q, add_amt, sat_add, sat_sub;
    logic [16:0] add_sum;
    logic [3:0]  life_q;
    logic [1:0]  combo_q;
    logic        event_q, over_q;

    assign coll_now = {bus.collisionBallBottom, bus.collisionBallCredit, bus.collisionBallObstacleBad,
                       bus.collisionBallObstacleGood, bus.collisionBallBumper};
    assign coll_ev  = coll_now & ~coll_prev_q;
    assign start_ev = bus.start & ~start_prev_q;

    // A level restart also suppresses servicing, so a pending event is dropped rather than applied.
    always_comb begin
        grant = '0;
        if (state_q == ST_PLAY && !bus.pause && !bus.reset_level_pulse) begin
            if      (pend_q[SRC_BOTTOM]) grant[SRC_BOTTOM] = 1'b1;
            else if (pend_q[SRC_CREDIT]) grant[SRC_CREDIT] = 1'b1;
            else if (pend_q[SRC_BAD])    grant[SRC_BAD]    = 1'b1;
            else if (pend_q[SRC_GOOD])   grant[SRC_GOOD]   = 1'b1;
            else if (pend_q[SRC_BUMPER]) grant[SRC_BUMPER] = 1'b1;
        end
    end

    always_comb begin
        pend_d = '0;
        if (state_q == ST_PLAY && !bus.reset_level_pulse)
            pend_d = (pend_q & ~grant) | coll_ev;
    end

    always_comb begin
        add_amt = 16'(POINTS_BUMPER);
        if (grant[SRC_GOOD])
            add_amt = 16'(POINTS_GOOD) << combo_q;
        add_sum = {1'b0, score_q} + {1'b0, add_amt};
        sat_add = add_sum[16] ? 16'hFFFF : add_sum[15:0];
        sat_sub = (score_q >= 16'(POINTS_BAD)) ? (score_q - 16'(POINTS_BAD)) : 16'd0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            coll_prev_q  <= '0;
            start_prev_q <= 1'b0;
            pend_q       <= '0;
            score_q      <= '0;
            life_q       <= '0;
            event_q      <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            coll_prev_q  <= coll_now;
            start_prev_q <= bus.start;
            pend_q       <= pend_d;
            event_q      <= |grant;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_ev) begin
                        state_q <= ST_PLAY;
                        score_q <= '0;
                        life_q  <= 4'(INIT_LIFE);
                        over_q  <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (grant[SRC_GOOD] || grant[SRC_BUMPER]) score_q <= sat_add;
                    if (grant[SRC_BAD])                       score_q <= sat_sub;
                    if (grant[SRC_CREDIT])
                        life_q <= (life_q >= 4'(LIFE_MAX)) ? 4'(LIFE_MAX) : life_q + 4'd1;
                    if (grant[SRC_BOTTOM]) begin
                        life_q <= (life_q == 4'd0) ? 4'd0 : life_q - 4'd1;
                        if (life_q <= 4'd1) begin
                            state_q <= ST_OVER;
                            over_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SCORE_COMBO_EN
    localparam int TW = $clog2(COMBO_WINDOW + 1);
    logic [TW-1:0] timer_q;
    logic          timer_sat, combo_clr;

    assign timer_sat = (timer_q == TW'(COMBO_WINDOW));
    assign combo_clr = bus.reset_level_pulse || (start_ev && state_q != ST_PLAY);

    // A Good hit scores with the old level, then climbs only if it landed inside the window.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timer_q <= '0;
            combo_q <= '0;
        end else if (combo_clr) begin
            timer_q <= '0;
            combo_q <= '0;
        end else begin
            if (grant[SRC_GOOD])
                timer_q <= '0;
            else if (bus.startOfFrame && !timer_sat)
                timer_q <= timer_q + TW'(1);

            if (grant[SRC_BAD] || grant[SRC_BOTTOM] || timer_sat)
                combo_q <= '0;
            else if (grant[SRC_GOOD] && combo_q != 2'd2)
                combo_q <= combo_q + 2'd1;
        end
    end
`else
    logic unused_cfg;
    assign combo_q    = 2'd0;
    assign unused_cfg = bus.startOfFrame ^ (COMBO_WINDOW == 0);
`endif

    assign bus.score      = score_q;
    assign bus.life       = life_q;
    assign bus.comboLevel = combo_q;
    assign bus.scoreEvent = event_q;
    assign bus.gameOver   = over_q;
endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed and randomized checks of score_event_scheduler against a rule-level game model.
module tb_score_event_scheduler;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   ev_cnt = 0;

    // Rule-level model of the game state.
    int m_score = 0, m_life = 0, m_combo = 0, m_timer = 0;
    bit m_play = 1'b0, m_over = 1'b0;

    // Source bit order: 4 Bottom, 3 Credit, 2 Bad, 1 Good, 0 Bumper.
    localparam logic [4:0] B_BUMPER = 5'b00001;
    localparam logic [4:0] B_GOOD   = 5'b00010;
    localparam logic [4:0] B_BAD    = 5'b00100;
    localparam logic [4:0] B_CREDIT = 5'b01000;
    localparam logic [4:0] B_BOTTOM = 5'b10000;

    score_event_scheduler_if ifc();

    score_event_scheduler dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ifc.scoreEvent === 1'b1) ev_cnt++;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic drive_coll(input logic [4:0] b);
        ifc.collisionBallBottom        = b[4];
        ifc.collisionBallCredit        = b[3];
        ifc.collisionBallObstacleBad   = b[2];
        ifc.collisionBallObstacleGood  = b[1];
        ifc.collisionBallBumper        = b[0];
    endtask

    task automatic hit(input logic [4:0] b);
        drive_coll(b);
        step();
        drive_coll(5'b0);
        step();
    endtask

    task automatic do_start();
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        step();
        m_play = 1'b1; m_over = 1'b0; m_score = 0; m_life = 3; m_combo = 0;
    endtask

    task automatic do_rlp();
        ifc.reset_level_pulse = 1'b1;
        step();
        ifc.reset_level_pulse = 1'b0;
        step();
        m_combo = 0; m_timer = 0;
    endtask

    task automatic frame();
        ifc.startOfFrame = 1'b1;
        step();
        ifc.startOfFrame = 1'b0;
        step();
`ifdef SCORE_COMBO_EN
        if (m_timer < 60) m_timer++;
        if (m_timer == 60) m_combo = 0;
`endif
    endtask

    // Applies the simultaneous events of one cycle in priority order; returns services performed.
    function automatic int model_hits(input logic [4:0] b);
        int n = 0;
        for (int s = 4; s >= 0; s--) begin
            if (b[s] && m_play) begin
                n++;
                case (s)
                    4: begin
                        m_life  = (m_life > 0) ? m_life - 1 : 0;
                        m_combo = 0;
                        if (m_life == 0) begin m_play = 1'b0; m_over = 1'b1; end
                    end
                    3: m_life = (m_life < 9) ? m_life + 1 : 9;
                    2: begin m_score = (m_score >= 5) ? m_score - 5 : 0; m_combo = 0; end
                    1: begin
                        m_score = m_score + (10 << m_combo);
                        if (m_score > 65535) m_score = 65535;
`ifdef SCORE_COMBO_EN
                        if (m_timer < 60) m_combo = (m_combo < 2) ? m_combo + 1 : 2;
                        else              m_combo = 0;
                        m_timer = 0;
`endif
                    end
                    default: m_score = (m_score < 65535) ? m_score + 1 : 65535;
                endcase
            end
        end
        return n;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_score"}, 32'(ifc.score), m_score);
        check({tag, "_life"},  32'(ifc.life), m_life);
        check({tag, "_combo"}, 32'(ifc.comboLevel), m_combo);
        check({tag, "_over"},  32'(ifc.gameOver), 32'(m_over));
    endtask

    initial begin
        int e0, n, s0, guard;
        logic [4:0] b;
        int exp_delta[3];

        ifc.startOfFrame = 1'b0; ifc.start = 1'b0; ifc.pause = 1'b0; ifc.reset_level_pulse = 1'b0;
        drive_coll(5'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_score", 32'(ifc.score), 0);
        check("rst_life", 32'(ifc.life), 0);
        check("rst_combo", 32'(ifc.comboLevel), 0);
        check("rst_event", 32'(ifc.scoreEvent), 0);
        check("rst_over", 32'(ifc.gameOver), 0);
        resetN = 1'b1;
        wait_n(2);

        // Events in IDLE are ignored.
        hit(B_GOOD);
        wait_n(3);
        check("idle_score", 32'(ifc.score), 0);
        check("idle_events", ev_cnt, 0);

        do_start();
        check_model("start");

        // First Good: pulse visible exactly two cycles after the input rises.
        e0 = ev_cnt;
        drive_coll(B_GOOD);
        step();
        check("good_evt_n1", 32'(ifc.scoreEvent), 0);
        drive_coll(5'b0);
        step();
        check("good_evt_n2", 32'(ifc.scoreEvent), 1);
        check("good_score", 32'(ifc.score), 10);
        step();
        check("good_evt_n3", 32'(ifc.scoreEvent), 0);
        check("good_single", ev_cnt - e0, 1);
        void'(model_hits(B_GOOD));

        // Bottom + Credit + Bumper together: three consecutive services in priority order.
        e0 = ev_cnt;
        s0 = m_score;
        drive_coll(B_BOTTOM | B_CREDIT | B_BUMPER);
        step();
        drive_coll(5'b0);
        step();
        check("tri_bottom_life", 32'(ifc.life), 2);
        step();
        check("tri_credit_life", 32'(ifc.life), 3);
        step();
        check("tri_bumper_score", 32'(ifc.score), s0 + 1);
        void'(model_hits(B_BOTTOM | B_CREDIT | B_BUMPER));
        check("tri_events", ev_cnt - e0, 3);
        check_model("tri");

        // Bring score to 3, then Bad clamps to 0 and still pulses.
        while (m_score > 3) begin hit(B_BAD); void'(model_hits(B_BAD)); end
        while (m_score < 3) begin hit(B_BUMPER); void'(model_hits(B_BUMPER)); end
        wait_n(2);
        check("pre_clamp_score", 32'(ifc.score), 3);
        hit(B_BAD);
        void'(model_hits(B_BAD));
        check("clamp_score", 32'(ifc.score), 0);
        check("clamp_event", 32'(ifc.scoreEvent), 1);

        // Pause holds a pending Good for 100 cycles, then it is serviced once.
        ifc.pause = 1'b1;
        e0 = ev_cnt;
        s0 = m_score;
        hit(B_GOOD);
        wait_n(100);
        check("pause_score", 32'(ifc.score), s0);
        check("pause_events", ev_cnt - e0, 0);
        ifc.pause = 1'b0;
        wait_n(3);
        void'(model_hits(B_GOOD));
        check("unpause_score", 32'(ifc.score), m_score);
        check("unpause_events", ev_cnt - e0, 1);

        // Level restart drops a pending event.
        ifc.pause = 1'b1;
        e0 = ev_cnt;
        hit(B_BUMPER);
        wait_n(2);
        do_rlp();
        ifc.pause = 1'b0;
        wait_n(4);
        check("rlp_events", ev_cnt - e0, 0);
        check_model("rlp");

        // Randomized rounds of simultaneous events against the model.
        for (int r = 0; r < 24; r++) begin
            b  = 5'($urandom_range(1, 31));
            e0 = ev_cnt;
            n  = model_hits(b);
            hit(b);
            wait_n(5);
            check_model("rand");
            check("rand_events", ev_cnt - e0, n);
            if (!m_play) begin
                do_start();
                do_rlp();
            end
        end

        // Drain lives to zero: game over, further events ignored, start reinitialises.
        guard = 0;
        while (m_play && guard < 12) begin
            hit(B_BOTTOM);
            void'(model_hits(B_BOTTOM));
            guard++;
        end
        wait_n(2);
        check("over_life", 32'(ifc.life), 0);
        check("over_flag", 32'(ifc.gameOver), 1);
        e0 = ev_cnt;
        s0 = m_score;
        hit(B_GOOD);
        wait_n(3);
        check("over_ignore_score", 32'(ifc.score), s0);
        check("over_ignore_events", ev_cnt - e0, 0);
        do_start();
        check("restart_score", 32'(ifc.score), 0);
        check("restart_life", 32'(ifc.life), 3);
        check("restart_over", 32'(ifc.gameOver), 0);

        // Combo: three Good hits ten frames apart, then sixty idle frames.
        do_rlp();
`ifdef SCORE_COMBO_EN
        exp_delta = '{10, 20, 40};
`else
        exp_delta = '{10, 10, 10};
`endif
        for (int k = 0; k < 3; k++) begin
            s0 = int'(ifc.score);
            hit(B_GOOD);
            void'(model_hits(B_GOOD));
            check("combo_delta", 32'(ifc.score) - 32'(s0), exp_delta[k]);
            if (k < 2) repeat (10) frame();
        end
        wait_n(1);
`ifdef SCORE_COMBO_EN
        check("combo_peak", 32'(ifc.comboLevel), 2);
`else
        check("combo_peak", 32'(ifc.comboLevel), 0);
`endif
        repeat (60) frame();
        wait_n(2);
        check("combo_expired", 32'(ifc.comboLevel), 0);
        check_model("combo");

        // Credit saturates at the ceiling.
        repeat (8) begin hit(B_CREDIT); void'(model_hits(B_CREDIT)); end
        wait_n(1);
        check("life_ceiling", 32'(ifc.life), 9);

        // Score saturation: climb to 65530, then Good saturates at 65535 and still pulses.
        do_rlp();
        guard = 0;
        while (m_score + (10 << m_combo) <= 65530 && guard < 8000) begin
            hit(B_GOOD);
            void'(model_hits(B_GOOD));
            guard++;
        end
        while (m_score < 65530 && guard < 8100) begin
            hit(B_BUMPER);
            void'(model_hits(B_BUMPER));
            guard++;
        end
        wait_n(1);
        check("sat_pre_score", 32'(ifc.score), 65530);
        hit(B_GOOD);
        void'(model_hits(B_GOOD));
        check("sat_score", 32'(ifc.score), 65535);
        check("sat_event", 32'(ifc.scoreEvent), 1);
        hit(B_GOOD);
        void'(model_hits(B_GOOD));
        check("sat_hold_score", 32'(ifc.score), 65535);
        check("sat_hold_event", 32'(ifc.scoreEvent), 1);

        // Asynchronous reset mid-game returns everything to idle values.
        #2 resetN = 1'b0;
        #1;
        check("arst_score", 32'(ifc.score), 0);
        check("arst_life", 32'(ifc.life), 0);
        resetN = 1'b1;
        wait_n(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
